// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor block: state encoding and the
// overlay page address constants.
package monitor_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ARMED   = 2'd1,
    OVERLAY = 2'd2,
    EXIT    = 2'd3
  } mon_state_e;

  localparam logic [7:0] OVL_PAGE = 8'hFF;
  localparam logic [7:0] VEC_LO   = 8'hFA;
  localparam logic [7:0] EXIT_LO  = 8'hFF;

endpackage

// File: rtl/monitor_overlay_bus_decode.sv
// Combinational decode of the 6502 bus cycle into the few address events
// the overlay FSM reacts to.
module bus_decode
  import monitor_pkg::*;
(
  input  logic        bus_valid,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_sync,
  output logic        ovl_hit,
  output logic        vec_hit,
  output logic        exit_wr,
  output logic        user_fetch
);

  logic in_page;

  assign in_page    = (cpu_addr[15:8] == OVL_PAGE);
  assign ovl_hit    = bus_valid & in_page;
  assign vec_hit    = bus_valid & cpu_rw & (cpu_addr == {OVL_PAGE, VEC_LO});
  assign exit_wr    = bus_valid & ~cpu_rw & (cpu_addr == {OVL_PAGE, EXIT_LO});
  // An opcode fetch outside the page means the RTI has landed in user code.
  assign user_fetch = bus_valid & cpu_sync & ~in_page;

endmodule

// File: rtl/monitor_overlay.sv
// Monitor overlay front end: raises NMI on a break request, maps page $FF
// onto control RAM from the NMI vector fetch until the CPU is back in user code.
module monitor_overlay
  import monitor_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // Handshake: bus_valid is a one-clk strobe per CPU bus cycle with no
  // back-pressure; cpu_addr/cpu_rw/cpu_sync are only meaningful while it is high.
  input  logic        bus_valid,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_sync,
  input  logic        break_req,
  output logic        nmi_n,
  output logic        ctl_cs,
  output logic [7:0]  ctl_addr,
  output logic        ctl_write,
  output logic        ext_mem_en,
  output logic [1:0]  state,
  output logic [7:0]  break_count,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mon_state_e    cur_state, nxt_state;
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          brk_ok;
  logic          overlay_acc;
  logic          tmo_hit;
  logic          ovl_hit, vec_hit, exit_wr, user_fetch;

  bus_decode u_decode (
    .bus_valid  (bus_valid),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_sync   (cpu_sync),
    .ovl_hit    (ovl_hit),
    .vec_hit    (vec_hit),
    .exit_wr    (exit_wr),
    .user_fetch (user_fetch)
  );

  always_comb begin
    nxt_state   = cur_state;
    tmo_cnt_nxt = '0;
    overlay_acc = 1'b0;
    tmo_hit     = 1'b0;
    case (cur_state)
      NORMAL: begin
        if (break_req && brk_ok) nxt_state = ARMED;
      end
      ARMED: begin
        tmo_cnt_nxt = tmo_cnt;
        // The vector fetch takes priority over a timeout on the same cycle.
        if (vec_hit) begin
          overlay_acc = 1'b1;
          nxt_state   = OVERLAY;
          tmo_cnt_nxt = '0;
        end else if (bus_valid) begin
          if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            tmo_hit     = 1'b1;
            nxt_state   = NORMAL;
            tmo_cnt_nxt = '0;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
          end
        end
      end
      OVERLAY: begin
        overlay_acc = ovl_hit;
        if (exit_wr) nxt_state = EXIT;
      end
      EXIT: begin
        overlay_acc = ovl_hit;
        if (user_fetch) nxt_state = NORMAL;
      end
      default: nxt_state = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= NORMAL;
      tmo_cnt     <= '0;
      brk_ok      <= 1'b0;
      ctl_cs      <= 1'b0;
      ctl_addr    <= 8'h00;
      ctl_write   <= 1'b0;
      ext_mem_en  <= 1'b1;
      break_count <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      tmo_cnt   <= tmo_cnt_nxt;
      // Blocks a break_req that coincides with the first edge after reset.
      brk_ok    <= 1'b1;
      ctl_cs    <= overlay_acc;
      ctl_addr  <= overlay_acc ? cpu_addr[7:0] : 8'h00;
      ctl_write <= overlay_acc & ~cpu_rw;
      if (bus_valid) ext_mem_en <= ~overlay_acc;
      if (cur_state == ARMED && vec_hit) begin
        break_count <= break_count + 8'd1;
        timeout_err <= 1'b0;
      end else if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign nmi_n = (cur_state != ARMED);
  assign state = cur_state;

endmodule

// File: tb/tb_monitor_overlay.sv
// Bench for monitor_overlay: randomized bus traffic checked against a
// behavioural model through an expected-response queue.
module tb_monitor_overlay;

  typedef struct packed {
    logic       ov;
    logic [7:0] addr;
    logic       wr;
    logic       ext;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       terr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        cpu_sync;
  logic        break_req;
  logic        nmi_n;
  logic        ctl_cs;
  logic [7:0]  ctl_addr;
  logic        ctl_write;
  logic        ext_mem_en;
  logic [1:0]  state;
  logic [7:0]  break_count;
  logic        timeout_err;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  // reference model state
  int         m_state;
  int         m_wait;
  logic [7:0] m_count;
  logic       m_terr;
  logic       m_ext;

  monitor_overlay #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_valid   (bus_valid),
    .cpu_addr    (cpu_addr),
    .cpu_rw      (cpu_rw),
    .cpu_sync    (cpu_sync),
    .break_req   (break_req),
    .nmi_n       (nmi_n),
    .ctl_cs      (ctl_cs),
    .ctl_addr    (ctl_addr),
    .ctl_write   (ctl_write),
    .ext_mem_en  (ext_mem_en),
    .state       (state),
    .break_count (break_count),
    .timeout_err (timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_wait  = 0;
    m_count = 8'h00;
    m_terr  = 1'b0;
    m_ext   = 1'b1;
  endtask

  task automatic push_exp(input logic ov, input logic [15:0] a, input logic rw);
    exp_t e;
    e.ov   = ov;
    e.addr = a[7:0];
    e.wr   = ~rw;
    e.ext  = m_ext;
    e.st   = 2'(m_state);
    e.cnt  = m_count;
    e.terr = m_terr;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_nmi_n", nmi_n, 1);
    chk("rst_ctl_cs", ctl_cs, 0);
    chk("rst_ctl_addr", ctl_addr, 0);
    chk("rst_ctl_write", ctl_write, 0);
    chk("rst_ext_mem_en", ext_mem_en, 1);
    chk("rst_state", state, 0);
    chk("rst_break_count", break_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  // driver tasks; the model is updated when each stimulus is issued
  task automatic bus(input logic [15:0] a, input logic rw, input logic sync);
    logic ov;
    logic page;
    @(negedge clk);
    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_sync  = sync;
    bus_valid = 1'b1;
    page = (a[15:8] == 8'hFF);
    ov   = 1'b0;
    case (m_state)
      1: begin
        m_wait++;
        if (rw && a == 16'hFFFA) begin
          ov = 1'b1; m_state = 2; m_count = m_count + 8'd1; m_terr = 1'b0; m_wait = 0;
        end else if (m_wait == 16) begin
          m_state = 0; m_terr = 1'b1; m_wait = 0;
        end
      end
      2: begin
        ov = page;
        if (!rw && a == 16'hFFFF) m_state = 3;
      end
      3: begin
        if (sync && !page) m_state = 0;
        else ov = page;
      end
      default: ov = 1'b0;
    endcase
    m_ext = ~ov;
    push_exp(ov, a, rw);
    @(negedge clk);
    bus_valid = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic brk();
    @(negedge clk);
    break_req = 1'b1;
    if (m_state == 0) begin
      m_state = 1;
      m_wait  = 0;
    end
    push_exp(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    break_req = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 16'hFFFA;
    if (r == 2) return 16'hFFFF;
    if (r < 6) return {8'hFF, 8'($urandom_range(0, 255))};
    return 16'($urandom_range(0, 16'hFEFF));
  endfunction

  // scoreboard monitor
  logic seen;
  logic last_ext;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen <= 1'b0;
    else        seen <= bus_valid | break_req;
  end

  initial begin
    exp_t e;
    last_ext = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_ext = 1'b1;
      end else if (seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ctl_cs", ctl_cs, e.ov);
          if (e.ov) begin
            chk("ctl_addr", ctl_addr, e.addr);
            chk("ctl_write", ctl_write, e.wr);
          end
          chk("ext_mem_en", ext_mem_en, e.ext);
          chk("state", state, e.st);
          chk("nmi_n", nmi_n, (e.st != 2'd1));
          chk("break_count", break_count, e.cnt);
          chk("timeout_err", timeout_err, e.terr);
          last_ext = e.ext;
        end
      end else begin
        chk("ctl_cs_idle", ctl_cs, 0);
        chk("ext_mem_en_hold", ext_mem_en, last_ext);
      end
    end
  end

  // stimulus
  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_rw    = 1'b1;
    cpu_sync  = 1'b0;
    break_req = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();

    // a break on the very edge that releases reset must be ignored
    rst_n     = 1'b1;
    break_req = 1'b1;
    push_exp(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    break_req = 1'b0;
    repeat (3) @(negedge clk);

    // plain user traffic
    repeat (4) bus(16'h1234, 1'b1, 1'b0);

    // break, vector fetch on the third bus cycle
    brk();
    bus(16'h2000, 1'b1, 1'b1);
    bus(16'h2001, 1'b1, 1'b0);
    bus(16'hFFFA, 1'b1, 1'b0);

    // overlay write and a stack read outside the page
    bus(16'hFFF2, 1'b0, 1'b0);
    bus(16'h0100, 1'b1, 1'b0);

    // exit strobe, RTI fetched from the overlay, return to user code
    bus(16'hFFFF, 1'b0, 1'b0);
    bus(16'hFFE0, 1'b1, 1'b1);
    bus(16'h0400, 1'b1, 1'b1);

    // timeout after 16 bus cycles
    brk();
    for (int i = 0; i < 16; i++) bus(16'($urandom_range(0, 16'hFEFF)), 1'b1, 1'b0);
    // vector fetch on the 16th cycle wins and clears the error
    brk();
    for (int i = 0; i < 15; i++) bus(16'($urandom_range(0, 16'hFEFF)), 1'b1, 1'b0);
    bus(16'hFFFA, 1'b1, 1'b0);
    bus(16'hFFFF, 1'b0, 1'b0);
    bus(16'h0400, 1'b1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) brk();
      else bus(rand_addr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // steer into EXIT, then reset mid-overlay
    for (int i = 0; i < 40 && m_state != 3; i++) begin
      if (m_state == 0)      brk();
      else if (m_state == 1) bus(16'hFFFA, 1'b1, 1'b0);
      else                   bus(16'hFFFF, 1'b0, 1'b0);
    end
    chk("reached_exit", state, 3);
    chk("queue_empty_before_reset", exp_q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 256 complete breaks wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      brk();
      bus(16'hFFFA, 1'b1, 1'b0);
      bus(16'hFFFF, 1'b0, 1'b0);
      bus(16'h8000, 1'b1, 1'b1);
    end
    repeat (5) @(negedge clk);
    chk("break_count_wrap", break_count, m_count);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
